// File: rtl/vector_arbiter.sv
// Round-robin arbiter sharing one RAM-backed vector between two requesters,
// with a watchdog that aborts a vector access whose ready never returns.
module vector_arbiter #(
    parameter int unsigned DATA_WIDTH     = 20,
    parameter int unsigned DATA_COUNT     = 64,
    parameter int unsigned INDEX_WIDTH    = $clog2(DATA_COUNT) + 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             rq_get,
    input  logic [1:0]             rq_insert,
    input  logic [INDEX_WIDTH-1:0] rq0_index,
    input  logic [DATA_WIDTH-1:0]  rq0_data_in,
    input  logic [INDEX_WIDTH-1:0] rq1_index,
    input  logic [DATA_WIDTH-1:0]  rq1_data_in,
    output logic [1:0]             ack,
    output logic                   err,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   owner,
    output logic                   busy,
    output logic [INDEX_WIDTH-1:0] vec_index,
    output logic                   vec_get,
    output logic                   vec_insert,
    output logic [DATA_WIDTH-1:0]  vec_data_in,
    input  logic [DATA_WIDTH-1:0]  vec_data_out,
    input  logic                   vec_ready
);

    localparam int unsigned TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_ACK    = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   op_ins_q, op_ins_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   owner_q, owner_d;
    logic [1:0]             ack_q, ack_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   busy_q, busy_d;
    logic [INDEX_WIDTH-1:0] vec_index_q, vec_index_d;
    logic                   vec_get_q, vec_get_d;
    logic                   vec_insert_q, vec_insert_d;
    logic [DATA_WIDTH-1:0]  vec_data_in_q, vec_data_in_d;

    logic [1:0] req;
    logic       grant_start;
    logic       grant_port;

    assign req         = rq_get | rq_insert;
    assign grant_start = vec_ready & (|req);

    // On a tie the port that did not win last time gets the vector.
    always_comb begin
        if (&req) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            op_ins_q      <= 1'b0;
            timer_q       <= '0;
            owner_q       <= 1'b0;
            ack_q         <= '0;
            err_q         <= 1'b0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            vec_index_q   <= '0;
            vec_get_q     <= 1'b0;
            vec_insert_q  <= 1'b0;
            vec_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            op_ins_q      <= op_ins_d;
            timer_q       <= timer_d;
            owner_q       <= owner_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            rd_data_q     <= rd_data_d;
            busy_q        <= busy_d;
            vec_index_q   <= vec_index_d;
            vec_get_q     <= vec_get_d;
            vec_insert_q  <= vec_insert_d;
            vec_data_in_q <= vec_data_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_start) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_WAIT;
            S_WAIT:   if (vec_ready || (timer_q == TIMER_LAST)) state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the winner at grant, pulse the vector op, capture the result.
    always_comb begin
        last_grant_d  = last_grant_q;
        op_ins_d      = op_ins_q;
        timer_d       = timer_q;
        owner_d       = owner_q;
        ack_d         = '0;
        err_d         = err_q;
        rd_data_d     = rd_data_q;
        busy_d        = (state_d != S_IDLE);
        vec_index_d   = vec_index_q;
        vec_get_d     = 1'b0;
        vec_insert_d  = 1'b0;
        vec_data_in_d = vec_data_in_q;
        case (state_q)
            S_IDLE: begin
                if (grant_start) begin
                    owner_d       = grant_port;
                    last_grant_d  = grant_port;
                    op_ins_d      = rq_insert[grant_port];
                    vec_index_d   = grant_port ? rq1_index : rq0_index;
                    vec_data_in_d = grant_port ? rq1_data_in : rq0_data_in;
                    vec_get_d     = ~rq_insert[grant_port];
                    vec_insert_d  = rq_insert[grant_port];
                end
            end
            S_SETTLE: begin
                timer_d = '0;
            end
            S_WAIT: begin
                if (vec_ready) begin
                    err_d = 1'b0;
                    ack_d = owner_q ? 2'b10 : 2'b01;
                    if (!op_ins_q) begin
                        rd_data_d = vec_data_out;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    ack_d     = owner_q ? 2'b10 : 2'b01;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign ack         = ack_q;
    assign err         = err_q;
    assign rd_data     = rd_data_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign vec_index   = vec_index_q;
    assign vec_get     = vec_get_q;
    assign vec_insert  = vec_insert_q;
    assign vec_data_in = vec_data_in_q;

endmodule

// File: tb/tb_vector_arbiter.sv
// Bench for vector_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_vector_arbiter;

    localparam int unsigned DW = 20;
    localparam int unsigned DC = 64;
    localparam int unsigned IW = $clog2(DC) + 2;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    rq_get = '0;
    logic [1:0]    rq_insert = '0;
    logic [IW-1:0] rq0_index = '0;
    logic [DW-1:0] rq0_data_in = '0;
    logic [IW-1:0] rq1_index = '0;
    logic [DW-1:0] rq1_data_in = '0;
    logic [1:0]    ack;
    logic          err;
    logic [DW-1:0] rd_data;
    logic          owner;
    logic          busy;
    logic [IW-1:0] vec_index;
    logic          vec_get;
    logic          vec_insert;
    logic [DW-1:0] vec_data_in;
    logic [DW-1:0] vec_data_out = '0;
    logic          vec_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // vector model controls
    int lat = 0;
    bit rand_lat = 1'b0;
    bit hang = 1'b0;
    bit auto_on = 1'b0;

    vector_arbiter #(
        .DATA_WIDTH(DW), .DATA_COUNT(DC), .INDEX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_get(rq_get), .rq_insert(rq_insert),
        .rq0_index(rq0_index), .rq0_data_in(rq0_data_in),
        .rq1_index(rq1_index), .rq1_data_in(rq1_data_in),
        .ack(ack), .err(err), .rd_data(rd_data), .owner(owner), .busy(busy),
        .vec_index(vec_index), .vec_get(vec_get), .vec_insert(vec_insert),
        .vec_data_in(vec_data_in), .vec_data_out(vec_data_out), .vec_ready(vec_ready)
    );

    always #5 clk = ~clk;

    // Vector stand-in: ready drops for a configurable time after each op, or forever when hung.
    initial begin
        logic [DW-1:0] vmem [256];
        int  vcnt;
        bit  hung;
        vcnt = 0;
        hung = 1'b0;
        for (int i = 0; i < 256; i++) vmem[i] = '0;
        forever begin
            @(negedge clk);
            if (!hang) hung = 1'b0;
            if (vec_get || vec_insert) begin
                if (vec_insert && !hang) vmem[vec_index] = vec_data_in;
                if (vec_get) vec_data_out = vmem[vec_index];
                if (hang) hung = 1'b1;
                else vcnt = rand_lat ? int'($urandom_range(0, 6)) : lat;
            end else if (vcnt > 0) begin
                vcnt--;
            end
            vec_ready = (vcnt == 0) && !hung;
        end
    end

    // Reference model: one transaction at a time, timed by edges elapsed since the grant.
    logic [DW-1:0] ref_mem [256];
    bit            m_busy, m_in_ack, m_last, m_port, m_ins;
    int            m_age;
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_data;
    logic [1:0]    e_ack;
    logic          e_err, e_get, e_ins, e_owner;
    logic [DW-1:0] e_rd, e_vdata;
    logic [IW-1:0] e_vidx;

    task automatic model_reset();
        m_busy = 1'b0; m_in_ack = 1'b0; m_last = 1'b1; m_port = 1'b0; m_ins = 1'b0;
        m_age = 0; m_idx = '0; m_data = '0;
        e_ack = '0; e_err = 1'b0; e_get = 1'b0; e_ins = 1'b0; e_owner = 1'b0;
        e_rd = '0; e_vdata = '0; e_vidx = '0;
    endtask

    task automatic model_finish(input bit timed_out);
        if (timed_out) begin
            e_err = 1'b1;
            e_rd  = '0;
        end else begin
            e_err = 1'b0;
            if (m_ins) ref_mem[m_idx] = m_data;
            else e_rd = ref_mem[m_idx];
        end
        e_ack = m_port ? 2'b10 : 2'b01;
        m_in_ack = 1'b1;
    endtask

    task automatic model_step();
        bit r0, r1;
        r0 = rq_get[0] | rq_insert[0];
        r1 = rq_get[1] | rq_insert[1];
        e_ack = '0; e_get = 1'b0; e_ins = 1'b0;
        if (m_in_ack) begin
            m_in_ack = 1'b0;
            m_busy   = 1'b0;
        end else if (!m_busy) begin
            if (vec_ready && (r0 || r1)) begin
                m_port  = (r0 && r1) ? !m_last : r1;
                m_last  = m_port;
                m_ins   = rq_insert[m_port];
                m_idx   = m_port ? rq1_index : rq0_index;
                m_data  = m_port ? rq1_data_in : rq0_data_in;
                m_busy  = 1'b1;
                m_age   = 0;
                e_owner = m_port;
                e_vidx  = m_idx;
                e_vdata = m_data;
                e_get   = !m_ins;
                e_ins   = m_ins;
            end
        end else begin
            m_age++;
            if (m_age >= 3) begin
                if (vec_ready) model_finish(1'b0);
                else if (m_age - 2 == int'(TO)) model_finish(1'b1);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("ack", 32'(ack), 32'(e_ack));
        if (e_ack != 2'b00) chk("err", 32'(err), 32'(e_err));
        chk("rd_data", 32'(rd_data), 32'(e_rd));
        chk("vec_get", 32'(vec_get), 32'(e_get));
        chk("vec_insert", 32'(vec_insert), 32'(e_ins));
        chk("vec_index", 32'(vec_index), 32'(e_vidx));
        chk("vec_data_in", 32'(vec_data_in), 32'(e_vdata));
        if (m_busy) chk("owner", 32'(owner), 32'(e_owner));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        compare();
    endtask

    task automatic auto_drive();
        int op;
        for (int n = 0; n < 2; n++) begin
            if ((rq_get[n] | rq_insert[n]) && ack[n]) begin
                rq_get[n]    = 1'b0;
                rq_insert[n] = 1'b0;
            end else if (!(rq_get[n] | rq_insert[n]) && ($urandom_range(0, 99) < 35)) begin
                op = int'($urandom_range(0, 2));
                rq_get[n]    = (op != 1);
                rq_insert[n] = (op != 0);
                if (n == 0) begin
                    rq0_index   = IW'($urandom_range(0, 63));
                    rq0_data_in = DW'($urandom);
                end else begin
                    rq1_index   = IW'($urandom_range(0, 63));
                    rq1_data_in = DW'($urandom);
                end
            end
        end
    endtask

    // One clock: check after the edge, then move to the falling edge to drive.
    task automatic step();
        cycle();
        @(negedge clk);
        if (auto_on) auto_drive();
    endtask

    task automatic run_until_ack(input logic port, output int cyc, output int n_get,
                                 output int n_ins, output int n_other);
        cyc = -1; n_get = 0; n_ins = 0; n_other = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            n_get += int'(vec_get);
            n_ins += int'(vec_insert);
            if (ack[!port]) n_other++;
            if (ack[port]) begin
                cyc = c;
                rq_get[port]    = 1'b0;
                rq_insert[port] = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int cyc, n_get, n_ins, n_other, n_ack, n_busy;
        int seq [8];
        int at  [8];
        int exp_seq [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_vec_get", 32'(vec_get), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;
        step();

        // port 0 insert, ready held low through two WAIT_READY samples
        lat = 4;
        rq_insert[0] = 1'b1; rq0_index = IW'(3); rq0_data_in = DW'(20'h1ABCD);
        run_until_ack(1'b0, cyc, n_get, n_ins, n_other);
        chk("t1_ack_latency", 32'(cyc), 32'd6);
        chk("t1_insert_pulses", 32'(n_ins), 32'd1);
        chk("t1_get_pulses", 32'(n_get), 32'd0);
        chk("t1_ack1", 32'(n_other), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        repeat (2) step();

        // port 1 reads it back
        rq_get[1] = 1'b1; rq1_index = IW'(3);
        run_until_ack(1'b1, cyc, n_get, n_ins, n_other);
        chk("t2_ack_latency", 32'(cyc), 32'd6);
        chk("t2_rd_data", 32'(rd_data), 32'h1ABCD);
        chk("t2_err", 32'(err), 32'd0);
        chk("t2_get_pulses", 32'(n_get), 32'd1);
        chk("t2_ack0", 32'(n_other), 32'd0);
        repeat (2) step();

        // both ports from reset, held: strict alternation at minimum spacing
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        lat = 0;
        rq_insert[0] = 1'b1; rq0_index = IW'(7); rq0_data_in = DW'(20'h00F0F);
        rq_get[1] = 1'b1; rq1_index = IW'(7);
        step();
        chk("t3_first_owner", 32'(owner), 32'd0);
        chk("t3_first_busy", 32'(busy), 32'd1);
        n_ack = 0;
        for (int c = 1; c <= 100 && n_ack < 8; c++) begin
            step();
            if (ack != 2'b00) begin
                seq[n_ack] = int'(ack[1]);
                at[n_ack]  = c;
                n_ack++;
            end
        end
        rq_get = '0; rq_insert = '0;
        chk("t3_ack_count", 32'(n_ack), 32'd8);
        for (int i = 0; i < n_ack; i++) chk("t3_grant_order", 32'(seq[i]), 32'(exp_seq[i]));
        for (int i = 1; i < n_ack; i++) chk("t3_spacing", 32'(at[i] - at[i-1]), 32'd5);
        repeat (3) step();

        // get and insert together: insert wins, single ack
        lat = 1;
        rq_get[0] = 1'b1; rq_insert[0] = 1'b1; rq0_index = IW'(9); rq0_data_in = DW'(20'h2468A);
        run_until_ack(1'b0, cyc, n_get, n_ins, n_other);
        chk("t4_insert_pulses", 32'(n_ins), 32'd1);
        chk("t4_get_pulses", 32'(n_get), 32'd0);
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ack != 2'b00) n_ack++;
        end
        chk("t4_extra_acks", 32'(n_ack), 32'd0);

        // watchdog: vector never returns ready
        lat = 0;
        hang = 1'b1;
        rq_get[1] = 1'b1; rq1_index = IW'(3);
        run_until_ack(1'b1, cyc, n_get, n_ins, n_other);
        chk("t5_timeout_latency", 32'(cyc), 32'(3 + TO));
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_rd_data", 32'(rd_data), 32'd0);
        rq_get[0] = 1'b1; rq0_index = IW'(3);
        n_busy = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_busy += int'(busy);
        end
        chk("t5_no_grant_while_not_ready", 32'(n_busy), 32'd0);
        hang = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 5 && n_busy == 0; c++) begin
            step();
            n_busy += int'(busy);
        end
        chk("t5_grant_after_ready", 32'(n_busy), 32'd1);
        run_until_ack(1'b0, cyc, n_get, n_ins, n_other);
        chk("t5_recovered_rd", 32'(rd_data), 32'h1ABCD);
        repeat (2) step();

        // reset during WAIT_READY
        lat = 10;
        rq_get[0] = 1'b1; rq0_index = IW'(9);
        repeat (4) step();
        cycle();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_rd_data", 32'(rd_data), 32'd0);
        chk("t6_owner", 32'(owner), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_vec_get", 32'(vec_get), 32'd0);
        chk("t6_vec_insert", 32'(vec_insert), 32'd0);
        chk("t6_vec_index", 32'(vec_index), 32'd0);
        chk("t6_vec_data_in", 32'(vec_data_in), 32'd0);
        @(negedge clk);
        rq_get = '0;
        n_ack = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (ack != 2'b00) n_ack++;
        end
        chk("t6_no_ack", 32'(n_ack), 32'd0);
        rst_n = 1'b1;
        repeat (12) step();

        // randomized traffic against the model
        rand_lat = 1'b1;
        auto_on = 1'b1;
        repeat (3000) step();
        auto_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
